// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the ID/EX control bundle type.
// Imported by the interface, the hazard detector and the pipeline register.
package rv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Seven control outputs that travel with an instruction into EX.
  typedef struct packed {
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    aluop_e aluop;
  } ctrl_t;

  // An instruction reads rs2 unless operand B is the immediate; stores read it regardless.
  function automatic logic uses_rs2(input logic alusrc, input logic memwrite);
    return ~alusrc | memwrite;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side inputs, registered EX-side outputs,
// flush/stall handshake and the bubble counter.
interface id_ex_stage_if
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
);

  logic              id_valid_i;
  logic              id_alusrc_i;
  logic              id_memtoreg_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              id_memwrite_i;
  logic              id_branch_i;
  logic [1:0]        id_aluop_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [RA_W-1:0]   id_rs1_i;
  logic [RA_W-1:0]   id_rs2_i;
  logic [RA_W-1:0]   id_rd_i;
  logic [2:0]        id_funct3_i;
  logic              id_funct7b5_i;
  logic              flush_i;

  logic              ex_valid_o;
  logic              ex_alusrc_o;
  logic              ex_memtoreg_o;
  logic              ex_regwrite_o;
  logic              ex_memread_o;
  logic              ex_memwrite_o;
  logic              ex_branch_o;
  logic [1:0]        ex_aluop_o;
  logic [XLEN-1:0]   ex_pc_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [RA_W-1:0]   ex_rs1_o;
  logic [RA_W-1:0]   ex_rs2_o;
  logic [RA_W-1:0]   ex_rd_o;
  logic [2:0]        ex_funct3_o;
  logic              ex_funct7b5_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  // Decode/hazard-control side.
  modport master (
    output id_valid_i, id_alusrc_i, id_memtoreg_i, id_regwrite_i, id_memread_i,
           id_memwrite_i, id_branch_i, id_aluop_i, id_pc_i, id_rs1_data_i,
           id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i,
           id_funct7b5_i, flush_i,
    input  ex_valid_o, ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memread_o,
           ex_memwrite_o, ex_branch_o, ex_aluop_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o,
           ex_funct7b5_o, stall_o, bubble_cnt_o
  );

  // The pipeline register itself.
  modport slave (
    input  id_valid_i, id_alusrc_i, id_memtoreg_i, id_regwrite_i, id_memread_i,
           id_memwrite_i, id_branch_i, id_aluop_i, id_pc_i, id_rs1_data_i,
           id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i,
           id_funct7b5_i, flush_i,
    output ex_valid_o, ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memread_o,
           ex_memwrite_o, ex_branch_o, ex_aluop_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o,
           ex_funct7b5_o, stall_o, bubble_cnt_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: the load in EX writes a register that the
// instruction in decode reads. Kept separate so forwarding changes stay local.
module load_use_detect
  import rv_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            ex_valid_i,
  input  logic            ex_memread_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            id_valid_i,
  input  logic            id_alusrc_i,
  input  logic            id_memwrite_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  output logic            load_use_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a dependency, so a load targeting it is harmless.
  assign ex_is_load = ex_valid_i & ex_memread_i & (ex_rd_i != '0);
  assign rs1_hit    = (ex_rd_i == id_rs1_i);
  assign rs2_hit    = uses_rs2(id_alusrc_i, id_memwrite_i) & (ex_rd_i == id_rs2_i);
  assign load_use_o = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control and operands, inserts a
// bubble on flush or load-use, and counts the bubbles it inserts (saturating).
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  ctrl_t             ctrl_d,     ctrl_q;
  logic              valid_d,    valid_q;
  logic [XLEN-1:0]   pc_d,       pc_q;
  logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
  logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]   imm_d,      imm_q;
  logic [RA_W-1:0]   rs1_d,      rs1_q;
  logic [RA_W-1:0]   rs2_d,      rs2_q;
  logic [RA_W-1:0]   rd_d,       rd_q;
  logic [2:0]        funct3_d,   funct3_q;
  logic              funct7b5_d, funct7b5_q;
  logic [CNT_W-1:0]  cnt_d,      cnt_q;

  logic load_use;
  logic counted_bubble;
  ctrl_t id_ctrl;

  load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_memread_i  (ctrl_q.memread),
    .ex_rd_i       (rd_q),
    .id_valid_i    (bus.id_valid_i),
    .id_alusrc_i   (bus.id_alusrc_i),
    .id_memwrite_i (bus.id_memwrite_i),
    .id_rs1_i      (bus.id_rs1_i),
    .id_rs2_i      (bus.id_rs2_i),
    .load_use_o    (load_use)
  );

  // A flush discards the decode instruction anyway, so there is nothing to hold.
  assign bus.stall_o   = load_use & ~bus.flush_i;
  assign counted_bubble = bus.flush_i | load_use;

  always_comb begin
    id_ctrl          = '0;
    id_ctrl.alusrc   = bus.id_alusrc_i;
    id_ctrl.memtoreg = bus.id_memtoreg_i;
    id_ctrl.regwrite = bus.id_regwrite_i;
    id_ctrl.memread  = bus.id_memread_i;
    id_ctrl.memwrite = bus.id_memwrite_i;
    id_ctrl.branch   = bus.id_branch_i;
    id_ctrl.aluop    = aluop_e'(bus.id_aluop_i);
  end

  // NOTE: every _d gets a default before the branches; a path that skipped one
  // would make synthesis infer a latch.
  always_comb begin
    ctrl_d     = '0;
    valid_d    = 1'b0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    funct3_d   = '0;
    funct7b5_d = 1'b0;
    cnt_d      = cnt_q;

    if (counted_bubble) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.id_valid_i) begin
      ctrl_d     = id_ctrl;
      valid_d    = 1'b1;
      pc_d       = bus.id_pc_i;
      rs1_data_d = bus.id_rs1_data_i;
      rs2_data_d = bus.id_rs2_data_i;
      imm_d      = bus.id_imm_i;
      rs1_d      = bus.id_rs1_i;
      rs2_d      = bus.id_rs2_i;
      rd_d       = bus.id_rd_i;
      funct3_d   = bus.id_funct3_i;
      funct7b5_d = bus.id_funct7b5_i;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_alusrc_o   = ctrl_q.alusrc;
  assign bus.ex_memtoreg_o = ctrl_q.memtoreg;
  assign bus.ex_regwrite_o = ctrl_q.regwrite;
  assign bus.ex_memread_o  = ctrl_q.memread;
  assign bus.ex_memwrite_o = ctrl_q.memwrite;
  assign bus.ex_branch_o   = ctrl_q.branch;
  assign bus.ex_aluop_o    = ctrl_q.aluop;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_rs1_data_o = rs1_data_q;
  assign bus.ex_rs2_data_o = rs2_data_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_o      = rs1_q;
  assign bus.ex_rs2_o      = rs2_q;
  assign bus.ex_rd_o       = rd_q;
  assign bus.ex_funct3_o   = funct3_q;
  assign bus.ex_funct7b5_o = funct7b5_q;
  assign bus.bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a default-width instance plus a CNT_W=2
// instance fed the same stimulus to exercise counter saturation.
module tb_id_ex_stage;
  import rv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus   ();
  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  bus_s ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  assign bus_s.id_valid_i    = bus.id_valid_i;
  assign bus_s.id_alusrc_i   = bus.id_alusrc_i;
  assign bus_s.id_memtoreg_i = bus.id_memtoreg_i;
  assign bus_s.id_regwrite_i = bus.id_regwrite_i;
  assign bus_s.id_memread_i  = bus.id_memread_i;
  assign bus_s.id_memwrite_i = bus.id_memwrite_i;
  assign bus_s.id_branch_i   = bus.id_branch_i;
  assign bus_s.id_aluop_i    = bus.id_aluop_i;
  assign bus_s.id_pc_i       = bus.id_pc_i;
  assign bus_s.id_rs1_data_i = bus.id_rs1_data_i;
  assign bus_s.id_rs2_data_i = bus.id_rs2_data_i;
  assign bus_s.id_imm_i      = bus.id_imm_i;
  assign bus_s.id_rs1_i      = bus.id_rs1_i;
  assign bus_s.id_rs2_i      = bus.id_rs2_i;
  assign bus_s.id_rd_i       = bus.id_rd_i;
  assign bus_s.id_funct3_i   = bus.id_funct3_i;
  assign bus_s.id_funct7b5_i = bus.id_funct7b5_i;
  assign bus_s.flush_i       = bus.flush_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic alusrc, input logic memtoreg,
                       input logic regwrite, input logic memread, input logic memwrite,
                       input logic branch, input logic [1:0] aluop,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] rs1_data, input logic [31:0] rs2_data,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.id_valid_i    = valid;
    bus.id_alusrc_i   = alusrc;
    bus.id_memtoreg_i = memtoreg;
    bus.id_regwrite_i = regwrite;
    bus.id_memread_i  = memread;
    bus.id_memwrite_i = memwrite;
    bus.id_branch_i   = branch;
    bus.id_aluop_i    = aluop;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_rs1_data_i = rs1_data;
    bus.id_rs2_data_i = rs2_data;
    bus.id_imm_i      = imm;
    bus.id_pc_i       = pc;
    bus.id_funct3_i   = 3'b000;
    bus.id_funct7b5_i = 1'b0;
  endtask

  task automatic drive_lw(input logic [4:0] rd);
    drive(1, 1, 1, 1, 1, 0, 0, ALUOP_ADD, 5'd1, 5'd0, rd, 32'h100, 32'h0, 32'h0, 32'h40);
  endtask

  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1, 0, 0, 1, 0, 0, 0, ALUOP_FUNCT, rs1, rs2, rd, 32'd5, 32'd7, 32'h0, 32'h44);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.flush_i = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          $urandom, $urandom, $urandom, $urandom);

    // Reset with random decode inputs: everything clears on the first edge.
    tick();
    check("rst_valid",    bus.ex_valid_o,    0);
    check("rst_regwrite", bus.ex_regwrite_o, 0);
    check("rst_memread",  bus.ex_memread_o,  0);
    check("rst_aluop",    bus.ex_aluop_o,    0);
    check("rst_rs1_data", bus.ex_rs1_data_o, 0);
    check("rst_rd",       bus.ex_rd_o,       0);
    check("rst_cnt",      bus.bubble_cnt_o,  0);
    tick();
    rst_n = 1'b1;

    // add x3,x1,x2 passes straight through.
    drive_add(5'd3, 5'd1, 5'd2);
    #1 check("add_stall_pre", bus.stall_o, 0);
    tick();
    check("add_valid",    bus.ex_valid_o,    1);
    check("add_regwrite", bus.ex_regwrite_o, 1);
    check("add_aluop",    bus.ex_aluop_o,    2'b10);
    check("add_rs1_data", bus.ex_rs1_data_o, 5);
    check("add_rs2_data", bus.ex_rs2_data_o, 7);
    check("add_rd",       bus.ex_rd_o,       3);
    check("add_stall",    bus.stall_o,       0);

    // lw x5 then add x6,x5,x1: one stall, one bubble, then the add advances.
    drive_lw(5'd5);
    tick();
    check("lw_memread", bus.ex_memread_o, 1);
    drive_add(5'd6, 5'd5, 5'd1);
    #1 check("lu_stall", bus.stall_o, 1);
    tick();
    check("lu_bubble_valid",    bus.ex_valid_o,    0);
    check("lu_bubble_regwrite", bus.ex_regwrite_o, 0);
    check("lu_cnt",             bus.bubble_cnt_o,  1);
    check("lu_stall_cleared",   bus.stall_o,       0);
    tick();
    check("lu_add_valid", bus.ex_valid_o, 1);
    check("lu_add_rd",    bus.ex_rd_o,    6);
    check("lu_add_rs1",   bus.ex_rs1_o,   5);
    check("lu_cnt_hold",  bus.bubble_cnt_o, 1);

    // lw x0 then a use of x0: no hazard.
    drive_lw(5'd0);
    tick();
    drive_add(5'd6, 5'd0, 5'd0);
    #1 check("x0_stall", bus.stall_o, 0);
    tick();

    // lw x5 then addi x6,x7,5 whose rs2 field happens to be 5: no hazard.
    drive_lw(5'd5);
    tick();
    drive(1, 1, 0, 1, 0, 0, 0, ALUOP_FUNCT, 5'd7, 5'd5, 5'd6, 32'd1, 32'd2, 32'd5, 32'h48);
    #1 check("addi_stall", bus.stall_o, 0);
    tick();

    // lw x5 then sw x5,0(x1): stores read rs2, so this stalls.
    drive_lw(5'd5);
    tick();
    drive(1, 1, 0, 0, 0, 1, 0, ALUOP_ADD, 5'd1, 5'd5, 5'd0, 32'h200, 32'h55, 32'h0, 32'h4c);
    #1 check("sw_stall", bus.stall_o, 1);
    tick();
    check("sw_bubble_valid", bus.ex_valid_o,     0);
    check("sw_cnt",          bus.bubble_cnt_o,   2);
    check("sw_cnt_small",    bus_s.bubble_cnt_o, 2);
    tick();
    check("sw_memwrite", bus.ex_memwrite_o, 1);

    // Flush with a valid branch in decode.
    drive(1, 0, 0, 0, 0, 0, 1, ALUOP_BR, 5'd1, 5'd2, 5'd0, 32'd3, 32'd3, 32'h10, 32'h50);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("fl_branch",    bus.ex_branch_o,    0);
    check("fl_valid",     bus.ex_valid_o,     0);
    check("fl_cnt",       bus.bubble_cnt_o,   3);
    check("fl_cnt_small", bus_s.bubble_cnt_o, 3);

    // Flush in a load-use cycle: no stall, a single bubble.
    drive_lw(5'd5);
    tick();
    drive_add(5'd6, 5'd5, 5'd1);
    bus.flush_i = 1'b1;
    #1 check("fllu_stall", bus.stall_o, 0);
    tick();
    check("fllu_valid",     bus.ex_valid_o,     0);
    check("fllu_cnt",       bus.bubble_cnt_o,   4);
    check("fllu_cnt_small", bus_s.bubble_cnt_o, 3);

    // Fifth bubble: the narrow counter stays saturated.
    tick();
    bus.flush_i = 1'b0;
    check("sat_cnt",       bus.bubble_cnt_o,   5);
    check("sat_cnt_small", bus_s.bubble_cnt_o, 3);

    // Invalid decode instruction: bubble without counting.
    drive(0, 0, 0, 1, 1, 0, 0, ALUOP_FUNCT, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 32'h54);
    tick();
    check("inv_valid",    bus.ex_valid_o,    0);
    check("inv_regwrite", bus.ex_regwrite_o, 0);
    check("inv_cnt",      bus.bubble_cnt_o,  5);

    // Reset arriving mid-stall clears the hazard and the counter.
    drive_lw(5'd5);
    tick();
    drive_add(5'd6, 5'd5, 5'd1);
    #1 check("rs_stall_pre", bus.stall_o, 1);
    rst_n = 1'b0;
    tick();
    check("rs_valid",   bus.ex_valid_o,   0);
    check("rs_memread", bus.ex_memread_o, 0);
    check("rs_rd",      bus.ex_rd_o,      0);
    check("rs_cnt",     bus.bubble_cnt_o, 0);
    check("rs_stall",   bus.stall_o,      0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
